sram_scanout_reader: RTL



---
 rtl/scanout_pkg.sv | 12 +
 rtl/scanout_fifo.sv | 54 +++++
 rtl/sram_scanout_reader.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/scanout_pkg.sv
// Shared widths, FSM encoding and default frame geometry for the SRAM scan-out reader.
package scanout_pkg;
   localparam int ADDR_W = 19;
   localparam int DATA_W = 16;

   localparam logic [ADDR_W-1:0] DEF_BASE_ADDR   = 19'd0;
   localparam logic [ADDR_W-1:0] DEF_FRAME_WORDS = 19'd307200;
   localparam int                DEF_FIFO_DEPTH  = 8;
   localparam int                DEF_RD_LAT      = 2;

   typedef enum logic [1:0] {IDLE, PREFETCH, STREAM, DRAIN} state_t;
endpackage

// File: rtl/scanout_fifo.sv
// Synchronous FWFT FIFO: head visible combinationally, push lands one edge later.
// Pop on empty is ignored; push on full is dropped unless a pop frees a slot on the same edge.
module scanout_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 16
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   flush,
   input  logic                   push,
   input  logic [W-1:0]           push_dat,
   input  logic                   pop,
   output logic [W-1:0]           head_dat,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic          do_push, do_pop;

   assign empty    = (count == '0);
   assign full     = (count == (AW+1)'(DEPTH));
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign head_dat = mem[rptr];

   always_ff @(posedge clk) begin
      if (do_push && !flush)
         mem[wptr] <= push_dat;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/sram_scanout_reader.sv
// Streams a frame of SRAM words through a prefetch FIFO to the pixel pipe; 1-clk pix_ce-to-data latency.
// Reads are throttled so buffered+in-flight never exceeds FIFO_DEPTH; SCANOUT_PIXEL_DOUBLE_EN repeats each word twice.
module sram_scanout_reader
   import scanout_pkg::*;
#(
   parameter logic [ADDR_W-1:0] BASE_ADDR   = DEF_BASE_ADDR,
   parameter logic [ADDR_W-1:0] FRAME_WORDS = DEF_FRAME_WORDS,
   parameter int                FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int                RD_LAT      = DEF_RD_LAT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              pix_ce,
   input  logic              frame_start,
   input  logic              in_display,
   output logic              sram_rd_req,
   input  logic              sram_rd_gnt,
   output logic [ADDR_W-1:0] sram_addr,
   input  logic [DATA_W-1:0] sram_q,
   output logic [DATA_W-1:0] pix_data,
   output logic              pix_valid,
   output logic              underflow
);
   localparam int                CNT_W     = $clog2(FIFO_DEPTH) + 2;
   localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = BASE_ADDR + FRAME_WORDS - 1'b1;
`ifdef SCANOUT_PIXEL_DOUBLE_EN
   localparam logic [ADDR_W-1:0] TOTAL     = FRAME_WORDS >> 1;
`else
   localparam logic [ADDR_W-1:0] TOTAL     = FRAME_WORDS;
`endif

   state_t                    state;
   logic [RD_LAT-1:0]         pipe;
   logic [ADDR_W-1:0]         issued, issued_nxt;
   logic [CNT_W-1:0]          inflight, committed, committed_nxt;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic [DATA_W-1:0]         fifo_head;
   logic                      fifo_empty, fifo_full, fifo_push;
   logic                      gnt_acc, slot, pop_slot, pop_ok, req_nxt;
`ifdef SCANOUT_PIXEL_DOUBLE_EN
   logic                      toggle;
`endif

   assign gnt_acc = sram_rd_req && sram_rd_gnt && !frame_start;
   assign slot    = pix_ce && in_display && !frame_start &&
                    ((state == STREAM) || (state == DRAIN));
`ifdef SCANOUT_PIXEL_DOUBLE_EN
   assign pop_slot = slot && !toggle;
`else
   assign pop_slot = slot;
`endif
   assign pop_ok    = pop_slot && !fifo_empty;
   assign fifo_push = pipe[RD_LAT-1] && (!fifo_full || pop_ok);

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LAT; i++)
         inflight = inflight + CNT_W'(pipe[i]);
   end

   // Budget counts every read already granted, so returns can never find the FIFO full.
   always_comb begin
      committed     = CNT_W'(fifo_count) + inflight;
      committed_nxt = committed + CNT_W'(gnt_acc) - CNT_W'(pop_ok);
      issued_nxt    = issued + ADDR_W'(gnt_acc);
      if (frame_start) begin
         committed_nxt = '0;
         issued_nxt    = '0;
      end
   end

   // Only PREFETCH/STREAM can stay requesting; exits from them happen when the budget or frame is exhausted.
   assign req_nxt = (frame_start || (state == PREFETCH) || (state == STREAM)) &&
                    (issued_nxt != TOTAL) && (committed_nxt < DEPTH_C);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         sram_rd_req <= 1'b0;
         sram_addr   <= BASE_ADDR;
         pix_data    <= '0;
         pix_valid   <= 1'b0;
         underflow   <= 1'b0;
         pipe        <= '0;
         issued      <= '0;
`ifdef SCANOUT_PIXEL_DOUBLE_EN
         toggle      <= 1'b0;
`endif
      end else begin
         sram_rd_req <= req_nxt;
         issued      <= issued_nxt;
         if (frame_start) begin
            state     <= PREFETCH;
            sram_addr <= BASE_ADDR;
            pipe      <= '0;
            underflow <= 1'b0;
`ifdef SCANOUT_PIXEL_DOUBLE_EN
            toggle    <= 1'b0;
`endif
         end else begin
            pipe <= (pipe << 1) | RD_LAT'(gnt_acc);
            if (gnt_acc)
               sram_addr <= (sram_addr == LAST_ADDR) ? BASE_ADDR : sram_addr + 1'b1;
            if (pop_slot) begin
               pix_data  <= fifo_empty ? '0 : fifo_head;
               pix_valid <= !fifo_empty;
               if (fifo_empty)
                  underflow <= 1'b1;
            end
`ifdef SCANOUT_PIXEL_DOUBLE_EN
            if (slot)
               toggle <= !toggle;
`endif
            case (state)
               PREFETCH: begin
                  if (issued_nxt == TOTAL)          state <= DRAIN;
                  else if (committed_nxt == DEPTH_C) state <= STREAM;
               end
               STREAM:   if (issued_nxt == TOTAL)   state <= DRAIN;
               DRAIN:    if (pop_ok && committed == CNT_W'(1)) state <= IDLE;
               default:  state <= state;
            endcase
         end
      end
   end

   scanout_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (DATA_W)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .flush    (frame_start),
      .push     (fifo_push),
      .push_dat (sram_q),
      .pop      (pop_ok),
      .head_dat (fifo_head),
      .count    (fifo_count),
      .empty    (fifo_empty),
      .full     (fifo_full)
   );
endmodule
